// File: rtl/cw_seq_pkg.sv
// Shared types and constants for the control-word sequencer.
package cw_seq_pkg;

    localparam int CW_WIDTH = 55;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int LEN_W    = ADDR_W + 1;

    localparam int FV = 3;
    localparam int FC = 2;
    localparam int FN = 1;
    localparam int FZ = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : l;
    endfunction

endpackage

// File: rtl/cw_seq_if.sv
// Load, control, playback and flag signals between host/datapath and sequencer.
interface cw_seq_if import cw_seq_pkg::*; ();

    logic                load_valid;
    logic [ADDR_W-1:0]   load_addr;
    logic [CW_WIDTH-1:0] load_data;
    logic                load_ready;
    logic                start;
    logic [LEN_W-1:0]    length;
    logic [3:0]          halt_mask;
    logic                abort;
    logic [CW_WIDTH-1:0] ControlWord;
    logic                cw_valid;
    logic                V;
    logic                C;
    logic                N;
    logic                Z;
    logic                busy;
    logic                done;
    logic                halted;
    logic [LEN_W-1:0]    issued;

    modport master (
        output load_valid, load_addr, load_data, start, length,
        output halt_mask, abort, V, C, N, Z,
        input  load_ready, ControlWord, cw_valid, busy, done,
        input  halted, issued
    );

    modport slave (
        input  load_valid, load_addr, load_data, start, length,
        input  halt_mask, abort, V, C, N, Z,
        output load_ready, ControlWord, cw_valid, busy, done,
        output halted, issued
    );

endinterface

// File: rtl/cw_mem.sv
// Control-word store: synchronous write, asynchronous read, not reset.
module cw_mem import cw_seq_pkg::*; (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [CW_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [CW_WIDTH-1:0] rdata
);

    logic [CW_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cw_sequencer.sv
// Plays back loaded control words one per cycle, halting on masked flags.
module cw_sequencer import cw_seq_pkg::*; (
    input logic clk,
    input logic rst,
    cw_seq_if.slave bus
);

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   nxt_pc;
    logic [ADDR_W-1:0]   raddr;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    start_len;
    logic [3:0]          mask_q;
    logic [3:0]          flags;
    logic [CW_WIDTH-1:0] rd;
    logic                we;
    logic                hit;
    logic                last;

    assign flags[FV] = bus.V;
    assign flags[FC] = bus.C;
    assign flags[FN] = bus.N;
    assign flags[FZ] = bus.Z;

    assign nxt_pc    = pc + 1'b1;
    assign raddr     = (state == RUN) ? nxt_pc : '0;
    assign we        = bus.load_valid && bus.load_ready;
    assign hit       = |(mask_q & flags);
    assign last      = (LEN_W'(pc) + LEN_W'(1)) == len_q;
    assign start_len = clamp_len(bus.length);

    // Entry 0 is read before a same-cycle write lands, so start sees the old word.
    cw_mem u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (raddr),
        .rdata (rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= '0;
            len_q           <= '0;
            mask_q          <= '0;
            bus.ControlWord <= '0;
            bus.cw_valid    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.halted      <= 1'b0;
            bus.issued      <= '0;
            bus.load_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q          <= start_len;
                        mask_q         <= bus.halt_mask;
                        pc             <= '0;
                        bus.halted     <= 1'b0;
                        bus.busy       <= 1'b1;
                        bus.load_ready <= 1'b0;
                        if (start_len == '0) begin
                            state      <= DONE;
                            bus.done   <= 1'b1;
                            bus.issued <= '0;
                        end else begin
                            state           <= RUN;
                            bus.ControlWord <= rd;
                            bus.cw_valid    <= 1'b1;
                            bus.issued      <= LEN_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (hit || bus.abort || last) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.cw_valid    <= 1'b0;
                        bus.ControlWord <= '0;
                        bus.halted      <= hit || bus.abort;
                    end else begin
                        pc              <= nxt_pc;
                        bus.ControlWord <= rd;
                        bus.issued      <= bus.issued + 1'b1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.done       <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.load_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cw_sequencer.sv
// Self-checking bench for cw_sequencer: table-driven runs plus reset corners.
module tb_cw_sequencer;
    import cw_seq_pkg::*;

    typedef struct {
        logic [4:0] len;
        logic [3:0] mask;
        int         fk;
        logic [3:0] fbits;
        int         ak;
        int         dk;
        bit         wr0;
        int         iss;
        bit         halt;
    } rec_t;

    logic clk = 0;
    logic rst = 1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [CW_WIDTH-1:0] model [DEPTH];
    logic [CW_WIDTH-1:0] q [$];
    rec_t                tbl [12];

    cw_seq_if bus ();

    cw_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [CW_WIDTH-1:0] word(input int i, input int s);
        return {23'(s * 131 + i * 7 + 1), 32'hC0DE0000 | 32'(i)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_drive();
        bus.start      = 0;
        bus.load_valid = 0;
        bus.abort      = 0;
        {bus.V, bus.C, bus.N, bus.Z} = 4'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cw"}, 64'(bus.ControlWord), 0);
        check({tag, "_cw_valid"}, 64'(bus.cw_valid), 0);
        check({tag, "_busy"}, 64'(bus.busy), 0);
        check({tag, "_done"}, 64'(bus.done), 0);
        check({tag, "_halted"}, 64'(bus.halted), 0);
        check({tag, "_issued"}, 64'(bus.issued), 0);
        check({tag, "_load_ready"}, 64'(bus.load_ready), 1);
    endtask

    task automatic run(input rec_t r);
        logic [CW_WIDTH-1:0] nw;
        bit seen;
        nw = word(0, 99);
        q.delete();
        for (int i = 0; i < r.iss; i++) q.push_back(model[i]);
        @(negedge clk);
        check("load_ready_idle", 64'(bus.load_ready), 1);
        bus.start     = 1;
        bus.length    = r.len;
        bus.halt_mask = r.mask;
        if (r.wr0) begin
            bus.load_valid = 1;
            bus.load_addr  = '0;
            bus.load_data  = nw;
        end
        @(negedge clk);
        idle_drive();
        if (r.wr0) model[0] = nw;
        seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (bus.cw_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_word: got %0h expected none",
                             bus.ControlWord);
                end else begin
                    check("cw", 64'(bus.ControlWord), 64'(q.pop_front()));
                end
                check("issued_run", 64'(bus.issued), 64'(k));
            end else begin
                check("cw_zero", 64'(bus.ControlWord), 0);
            end
            if (bus.done) begin
                seen = 1;
                check("done_cycle", 64'(k), 64'(r.iss + 1));
                check("issued", 64'(bus.issued), 64'(r.iss));
                check("halted", 64'(bus.halted), 64'(r.halt));
                check("busy_done", 64'(bus.busy), 1);
                check("leftover", 64'(q.size()), 0);
            end else begin
                {bus.V, bus.C, bus.N, bus.Z} = (k == r.fk) ? r.fbits : 4'b0;
                bus.abort = (k == r.ak);
                if (k == r.dk) begin
                    bus.start      = 1;
                    bus.load_valid = 1;
                    bus.load_addr  = '0;
                    bus.load_data  = ~model[0];
                end
            end
            @(negedge clk);
            idle_drive();
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done");
        end
        check("load_ready_after", 64'(bus.load_ready), 1);
        check("busy_after", 64'(bus.busy), 0);
        check("done_after", 64'(bus.done), 0);
    endtask

    initial begin
        // len, mask, fk, fbits, ak, dk, wr0, iss, halt
        tbl[0]  = '{5'd3,  4'b0000, 0, 4'b0000, 0, 0, 0, 3,  0};
        tbl[1]  = '{5'd0,  4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0};
        tbl[2]  = '{5'd5,  4'b0001, 2, 4'b0001, 0, 0, 0, 2,  1};
        tbl[3]  = '{5'd20, 4'b0000, 0, 4'b0000, 0, 0, 0, 16, 0};
        tbl[4]  = '{5'd16, 4'b0000, 0, 4'b0000, 0, 0, 0, 16, 0};
        tbl[5]  = '{5'd5,  4'b1000, 2, 4'b0001, 0, 0, 0, 5,  0};
        tbl[6]  = '{5'd6,  4'b0000, 0, 4'b0000, 3, 0, 0, 3,  1};
        tbl[7]  = '{5'd4,  4'b0100, 4, 4'b0100, 0, 0, 0, 4,  1};
        tbl[8]  = '{5'd4,  4'b0000, 0, 4'b0000, 0, 2, 0, 4,  0};
        tbl[9]  = '{5'd1,  4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0};
        tbl[10] = '{5'd2,  4'b0000, 0, 4'b0000, 0, 0, 1, 2,  0};
        tbl[11] = '{5'd1,  4'b0000, 0, 4'b0000, 0, 0, 0, 1,  0};

        idle_drive();
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.length    = '0;
        bus.halt_mask = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < DEPTH; i++) begin
            model[i]       = word(i, 1);
            bus.load_valid = 1;
            bus.load_addr  = ADDR_W'(i);
            bus.load_data  = model[i];
            @(negedge clk);
        end
        bus.load_valid = 0;

        for (int i = 0; i < 12; i++) run(tbl[i]);

        // Reset in the middle of a 4-word run.
        @(negedge clk);
        bus.start     = 1;
        bus.length    = 5'd4;
        bus.halt_mask = 4'b0;
        @(negedge clk);
        idle_drive();
        check("rst_run_w0", 64'(bus.ControlWord), 64'(model[0]));
        @(negedge clk);
        check("rst_run_w1", 64'(bus.ControlWord), 64'(model[1]));
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_vals("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", 64'(bus.done), 0);
            check("midrst_no_valid", 64'(bus.cw_valid), 0);
        end
        run('{5'd4, 4'b0000, 0, 4'b0000, 0, 0, 0, 4, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
